// File: rtl/wdt_pkg.sv
// Shared types and helpers for the watchdog reset controller.
package wdt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WARN  = 2'd1;
    localparam logic [1:0] ST_RESET = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WARN  = ST_WARN,
        RESET = ST_RESET,
        CLEAR = ST_CLEAR
    } wdt_state_t;

    // Wide enough to hold the larger of the two load values with one bit of headroom.
    function automatic int tmr_width(input int grace, input int pulse);
        return $clog2((grace > pulse) ? grace : pulse) + 1;
    endfunction

endpackage

// File: rtl/wdt_cycle_timer.sv
// Loadable down-counter shared by the grace window and the reset pulse.
module wdt_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog timeout handler: warning irq, grace window, then a fixed system reset pulse.
// Grace window / irq path is built only when WDT_RSTCTRL_GRACE_EN is defined.
module wdt_reset_ctrl
    import wdt_pkg::*;
#(
    parameter int GRACE_CYCLES     = 8,
    parameter int RST_PULSE_CYCLES = 4,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timeout,
    input  logic             irq_ack,
    output logic             irq,
    output logic             wd_restart,
    output logic             sys_rst_n,
    output logic [CNT_W-1:0] rst_count,
    output logic [1:0]       state_o
);

    localparam int TW = tmr_width(GRACE_CYCLES, RST_PULSE_CYCLES);
    localparam logic [TW-1:0] RST_LD = TW'(RST_PULSE_CYCLES - 1);
`ifdef WDT_RSTCTRL_GRACE_EN
    localparam logic [TW-1:0] GRACE_LD = TW'(GRACE_CYCLES - 1);
`endif

    wdt_state_t    state, state_nx;
    logic          t_load, t_dec, t_zero, cnt_inc;
    logic [TW-1:0] t_load_val;

    wdt_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_load_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_comb begin
        state_nx   = state;
        t_load     = 1'b0;
        t_load_val = RST_LD;
        t_dec      = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (timeout) begin
`ifdef WDT_RSTCTRL_GRACE_EN
                    state_nx   = WARN;
                    t_load     = 1'b1;
                    t_load_val = GRACE_LD;
`else
                    state_nx   = RESET;
                    t_load     = 1'b1;
                    cnt_inc    = 1'b1;
`endif
                end
            end
            WARN: begin
`ifdef WDT_RSTCTRL_GRACE_EN
                // Ack wins over a withdrawn timeout, which wins over expiry.
                if (irq_ack) begin
                    state_nx = CLEAR;
                end else if (!timeout) begin
                    state_nx = IDLE;
                end else if (t_zero) begin
                    state_nx = RESET;
                    t_load   = 1'b1;
                    cnt_inc  = 1'b1;
                end else begin
                    t_dec = 1'b1;
                end
`else
                state_nx = IDLE;
`endif
            end
            RESET: begin
                if (t_zero) state_nx = CLEAR;
                else        t_dec    = 1'b1;
            end
            CLEAR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wd_restart <= 1'b0;
            sys_rst_n  <= 1'b1;
            rst_count  <= '0;
        end else begin
            state      <= state_nx;
            wd_restart <= (state_nx == RESET) || (state_nx == CLEAR);
            sys_rst_n  <= (state_nx != RESET);
            if (cnt_inc && (rst_count != '1)) rst_count <= rst_count + CNT_W'(1);
        end
    end

`ifdef WDT_RSTCTRL_GRACE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (state_nx == WARN);
    end
`else
    logic unused_ack;
    assign unused_ack = irq_ack;
    assign irq        = 1'b0;
`endif

    assign state_o = state;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Scoreboard bench for wdt_reset_ctrl; expectations follow WDT_RSTCTRL_GRACE_EN.
module tb_wdt_reset_ctrl;

    localparam int G  = 8;
    localparam int R  = 4;
    localparam int CW = 2;
`ifdef WDT_RSTCTRL_GRACE_EN
    localparam bit GR = 1'b1;
`else
    localparam bit GR = 1'b0;
`endif
    localparam int K_UNS = 0;
    localparam int K_ACK = 1;
    localparam int K_WD  = 2;

    logic          clk = 1'b0;
    logic          rst_n, timeout, irq_ack;
    logic          irq, wd_restart, sys_rst_n;
    logic [CW-1:0] rst_count;
    logic [1:0]    state_o;

    typedef struct {
        int st;
        int irq;
        int wdr;
        int srn;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_run    = 0;
    int   n_fail   = 0;
    int   cnt_base = 0;

    wdt_reset_ctrl #(
        .GRACE_CYCLES     (G),
        .RST_PULSE_CYCLES (R),
        .CNT_W            (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timeout    (timeout),
        .irq_ack    (irq_ack),
        .irq        (irq),
        .wd_restart (wd_restart),
        .sys_rst_n  (sys_rst_n),
        .rst_count  (rst_count),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " state"}, 32'(state_o), e.st);
        chk({tag, " irq"}, 32'(irq), e.irq);
        chk({tag, " wd_restart"}, 32'(wd_restart), e.wdr);
        chk({tag, " sys_rst_n"}, 32'(sys_rst_n), e.srn);
        chk({tag, " rst_count"}, 32'(rst_count), e.cnt);
    endtask

    // Expected state in cycle c; timeout is first high in cycle 10.
    function automatic int exp_state(input int kind, input int c, input int p);
        if (c <= 10) return 0;
        if (GR) begin
            case (kind)
                K_UNS: begin
                    if (c <= 10 + G)     return 1;
                    if (c <= 10 + G + R) return 2;
                    if (c == 11 + G + R) return 3;
                    return 0;
                end
                K_ACK: begin
                    if (c <= p)     return 1;
                    if (c == p + 1) return 3;
                    return 0;
                end
                default: begin
                    if (c <= p) return 1;
                    return 0;
                end
            endcase
        end else begin
            if (c <= 10 + R) return 2;
            if (c == 11 + R) return 3;
            return 0;
        end
    endfunction

    task automatic push_exp(input int st, input int cnt);
        exp_t e;
        e.st  = st;
        e.irq = (st == 1) ? 1 : 0;
        e.wdr = (st >= 2) ? 1 : 0;
        e.srn = (st == 2) ? 0 : 1;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic run_scn(input string nm, input int kind, input int p,
                           input int ack_at, input int mid_rst);
        int to_hi, rs, last, cnt_new;
        to_hi   = (kind == K_UNS) ? (GR ? 10 + G : 10) : (kind == K_ACK) ? p : p - 1;
        rs      = GR ? 11 + G : 11;
        last    = (mid_rst >= 0) ? mid_rst : 25;
        cnt_new = (kind == K_UNS) ? ((cnt_base < 3) ? cnt_base + 1 : 3) : cnt_base;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            timeout = (c >= 10) && (c <= to_hi);
            irq_ack = (c == ack_at);
            if (c == mid_rst) rst_n = 1'b0;
            push_exp(exp_state(kind, c, p), (kind == K_UNS && c >= rs) ? cnt_new : cnt_base);
            @(negedge clk);
            chk_out($sformatf("%s c%0d", nm, c));
        end
        if (mid_rst >= 0) begin
            @(posedge clk);
            #1;
            rst_n    = 1'b1;
            timeout  = 1'b0;
            irq_ack  = 1'b0;
            cnt_base = 0;
            push_exp(0, 0);
            @(negedge clk);
            chk_out({nm, " after_rst"});
        end else begin
            cnt_base = cnt_new;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        timeout = 1'b1;
        irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_exp(0, 0);
        chk_out("reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        timeout = 1'b0;
        if (GR) begin
            run_scn("serviced", K_ACK, 14, 14, -1);
            run_scn("unserviced", K_UNS, 0, 12 + G, -1);
            run_scn("ack_at_expiry", K_ACK, 10 + G, 10 + G, -1);
            run_scn("withdrawn", K_WD, 13, -1, -1);
            for (int i = 0; i < 3; i++) run_scn($sformatf("sat%0d", i), K_UNS, 0, -1, -1);
            run_scn("mid_reset", K_UNS, 0, -1, 12 + G);
        end else begin
            for (int i = 0; i < 4; i++) run_scn($sformatf("nograce%0d", i), K_UNS, 0, 12, -1);
            run_scn("mid_reset", K_UNS, 0, -1, 12);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1, "bench time limit");
    end

endmodule
